// File: rtl/contador_comparador_param_pkg.sv
// Shared constants for the counter/comparator datapath: modo encoding and
// active-low 7-segment patterns ({g,f,e,d,c,b,a}) for hex digits 0..F.
package contador_comparador_param_pkg;

  localparam logic MODO_CRESC = 1'b0;
  localparam logic MODO_DECR  = 1'b1;

  function automatic logic [6:0] hex7seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/contador_comparador_param_m_ud.sv
// Modulo-MODULO up/down counter with synchronous clear, saturating load and
// enable; fim flags the terminal count for the current direction.
module contador_m_ud
  import contador_comparador_param_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clock,
  input  logic             zera_n,
  input  logic             zera,
  input  logic             carrega,
  input  logic             conta,
  input  logic             modo,
  input  logic [WIDTH-1:0] chaves,
  output logic [WIDTH-1:0] contagem,
  output logic             fim
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] contagem_next;

  // NOTE: the hold value is assigned first so every path through the block
  // writes contagem_next; leaving a path unassigned would infer a latch.
  always_comb begin
    contagem_next = contagem;
    if (zera) begin
      contagem_next = '0;
    end else if (carrega) begin
      contagem_next = (chaves > CNT_MAX) ? CNT_MAX : chaves;
    end else if (conta) begin
      if (modo == MODO_DECR) begin
        contagem_next = (contagem == '0) ? CNT_MAX : contagem - 1'b1;
      end else begin
        contagem_next = (contagem == CNT_MAX) ? '0 : contagem + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignment keeps every register sampling the values
  // from before the edge, independent of block ordering.
  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      contagem <= '0;
    end else begin
      contagem <= contagem_next;
    end
  end

  // Terminal count behaves like an rco with enable tied high.
  assign fim = (modo == MODO_DECR) ? (contagem == '0) : (contagem == CNT_MAX);

endmodule

// File: rtl/contador_comparador_param.sv
// Parametrised counter/comparator datapath: modulo up/down counter, unsigned
// compare against chaves, registered wrap pulse and multi-digit hex display.
module contador_comparador_param
  import contador_comparador_param_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic                              clock,
  input  logic                              zera_n,
  input  logic                              zera,
  input  logic                              carrega,
  input  logic                              conta,
  input  logic                              modo,
  input  logic [WIDTH-1:0]                  chaves,
  output logic                              menor,
  output logic                              maior,
  output logic                              igual,
  output logic                              fim,
  output logic                              pulso_fim,
  output logic [WIDTH-1:0]                  db_contagem,
  output logic [7*((WIDTH + 3) / 4)-1:0]    display
);

  localparam int DIGITS = (WIDTH + 3) / 4;
  localparam int NIB_W  = 4 * DIGITS;

  logic [WIDTH-1:0] contagem;
  logic [NIB_W-1:0] contagem_ext;

  contador_m_ud #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_contador (
    .clock    (clock),
    .zera_n   (zera_n),
    .zera     (zera),
    .carrega  (carrega),
    .conta    (conta),
    .modo     (modo),
    .chaves   (chaves),
    .contagem (contagem),
    .fim      (fim)
  );

  assign db_contagem = contagem;

  assign menor = (contagem <  chaves);
  assign maior = (contagem >  chaves);
  assign igual = (contagem == chaves);

  // A counting edge taken while fim is high is exactly a wrap edge.
  always_ff @(posedge clock or negedge zera_n) begin
    if (!zera_n) begin
      pulso_fim <= 1'b0;
    end else begin
      pulso_fim <= conta & fim & ~zera & ~carrega;
    end
  end

  // Nibbles beyond WIDTH read as zero.
  assign contagem_ext = NIB_W'(contagem);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign display[7*k +: 7] = hex7seg(contagem_ext[4*k +: 4]);
  end

endmodule
